// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit controller slice.
// Provides the FSM state encodings and the elaboration-time helpers that
// turn the clock/baud parameters into a bit period and a timer width.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Clocks per line bit; the integer divide truncates.
  function automatic int unsigned calc_bit_cyc(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

  // Bits needed to count 0..bit_cyc-1 (never narrower than 1).
  function automatic int unsigned timer_w(input int unsigned bit_cyc);
    return (bit_cyc < 2) ? 1 : $clog2(bit_cyc);
  endfunction

endpackage

// File: rtl/uart_tx_arb_ctrl_if.sv
// Byte-request and serial-line bundle of uart_tx_arb_ctrl.
//   slave  : the controller (takes requests, drives ready/tx/status)
//   master : the requesters and line observer
interface uart_tx_arb_ctrl_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       tx;
  logic       busy;
  logic       grant_id;
  logic       frame_done;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready, tx, busy, grant_id, frame_done
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready, tx, busy, grant_id, frame_done
  );
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period counter for the UART transmitter.
//   clk, rst : clock, asynchronous active-high reset
//   i_en     : count enable; the counter is held at 0 while low
//   o_tick   : high on the last clock of each BIT_CYC-clock bit period
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned BIT_CYC = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_tick
);

  localparam int unsigned     W    = timer_w(BIT_CYC);
  localparam logic [W-1:0]    LAST = W'(BIT_CYC - 1);

  logic [W-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_en || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_arb_ctrl.sv
// Two-requester UART transmit controller.
// Round-robin arbitrates byte requests and sends one frame per grant:
// start, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
//   clk, rst   : clock, asynchronous active-high reset
//   bus.req*   : valid/data/ready byte handshakes (ready only in IDLE)
//   bus.tx     : registered serial line, idle high
//   bus.busy   : frame in progress
//   bus.grant_id   : requester owning the current/last frame
//   bus.frame_done : one-cycle pulse as the last stop bit ends
module uart_tx_arb_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arb_ctrl_if.slave bus
);

  localparam int unsigned BIT_CYC = calc_bit_cyc(CLK_HZ, BAUD);

  if (BIT_CYC < 2) begin : g_bad_bit_cyc
    $error("uart_tx_arb_ctrl: CLK_HZ/BAUD must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_arb_ctrl: STOP_BITS must be 1 or 2");
  end

  logic [2:0] r_state;
  logic [7:0] r_byte;
  logic       r_parity;
  logic [2:0] r_bit_idx;
  logic       r_stop_idx;
  logic       r_tx;
  logic       r_gid;
  logic       r_rr;
  logic       r_done;

  logic       w_idle;
  logic       w_rdy0;
  logic       w_rdy1;
  logic       w_acc;
  logic       w_win;
  logic [7:0] w_data;
  logic       w_tick;

  // Arbiter: a lone valid wins; on contention the rr pointer decides.
  assign w_idle = (r_state == ST_IDLE);
  assign w_rdy0 = w_idle && bus.req0_valid && (!bus.req1_valid || !r_rr);
  assign w_rdy1 = w_idle && bus.req1_valid && (!bus.req0_valid ||  r_rr);
  assign w_acc  = w_rdy0 || w_rdy1;
  assign w_win  = w_rdy1;
  assign w_data = w_rdy1 ? bus.req1_data : bus.req0_data;

  assign bus.req0_ready = w_rdy0;
  assign bus.req1_ready = w_rdy1;
  assign bus.tx         = r_tx;
  assign bus.busy       = !w_idle;
  assign bus.grant_id   = r_gid;
  assign bus.frame_done = r_done;

  uart_bit_timer #(
    .BIT_CYC (BIT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .i_en   (!w_idle),
    .o_tick (w_tick)
  );

  // tx is loaded on each state transition with the level of the bit being
  // entered, so the line stays registered with no output decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_byte     <= '0;
      r_parity   <= 1'b0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_tx       <= 1'b1;
      r_gid      <= 1'b0;
      r_rr       <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_acc) begin
            r_byte   <= w_data;
            r_parity <= (PARITY_ODD != 0) ? ~^w_data : ^w_data;
            r_gid    <= w_win;
            r_rr     <= ~w_win;
            r_tx     <= 1'b0;
            r_state  <= ST_START;
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_bit_idx <= '0;
            r_tx      <= r_byte[0];
            r_state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            if (r_bit_idx == 3'd7) begin
              if (PARITY_EN != 0) begin
                r_tx    <= r_parity;
                r_state <= ST_PARITY;
              end else begin
                r_tx       <= 1'b1;
                r_stop_idx <= 1'b0;
                r_state    <= ST_STOP;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_byte[r_bit_idx + 3'd1];
            end
          end
        end
        ST_PARITY: begin
          if (w_tick) begin
            r_tx       <= 1'b1;
            r_stop_idx <= 1'b0;
            r_state    <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            if (r_stop_idx == 1'(STOP_BITS - 1)) begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_stop_idx <= 1'b1;
            end
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb_ctrl.sv
// Directed bench for uart_tx_arb_ctrl. Four instances share clk/rst:
//   0: defaults (8N1, 868 clk/bit)   1: 10 clk/bit, even parity
//   2: 10 clk/bit, odd parity        3: 10 clk/bit, 2 stop bits
// 'sel' routes the observed outputs of one instance to the checkers.
module tb_uart_tx_arb_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  logic       r0v [4];
  logic       r1v [4];
  logic [7:0] r0d [4];
  logic [7:0] r1d [4];
  int unsigned sel = 0;

  uart_tx_arb_ctrl_if ifa ();
  uart_tx_arb_ctrl_if ifb ();
  uart_tx_arb_ctrl_if ifc ();
  uart_tx_arb_ctrl_if ifd ();

  assign ifa.req0_valid = r0v[0];
  assign ifa.req0_data  = r0d[0];
  assign ifa.req1_valid = r1v[0];
  assign ifa.req1_data  = r1d[0];
  assign ifb.req0_valid = r0v[1];
  assign ifb.req0_data  = r0d[1];
  assign ifb.req1_valid = r1v[1];
  assign ifb.req1_data  = r1d[1];
  assign ifc.req0_valid = r0v[2];
  assign ifc.req0_data  = r0d[2];
  assign ifc.req1_valid = r1v[2];
  assign ifc.req1_data  = r1d[2];
  assign ifd.req0_valid = r0v[3];
  assign ifd.req0_data  = r0d[3];
  assign ifd.req1_valid = r1v[3];
  assign ifd.req1_data  = r1d[3];

  uart_tx_arb_ctrl u_dut_a (
    .clk (clk), .rst (rst), .bus (ifa.slave)
  );
  uart_tx_arb_ctrl #(
    .CLK_HZ (1_000_000), .BAUD (100_000), .PARITY_EN (1), .PARITY_ODD (0)
  ) u_dut_b (
    .clk (clk), .rst (rst), .bus (ifb.slave)
  );
  uart_tx_arb_ctrl #(
    .CLK_HZ (1_000_000), .BAUD (100_000), .PARITY_EN (1), .PARITY_ODD (1)
  ) u_dut_c (
    .clk (clk), .rst (rst), .bus (ifc.slave)
  );
  uart_tx_arb_ctrl #(
    .CLK_HZ (1_000_000), .BAUD (100_000), .STOP_BITS (2)
  ) u_dut_d (
    .clk (clk), .rst (rst), .bus (ifd.slave)
  );

  logic w_tx, w_busy, w_fd, w_gid, w_rdy0, w_rdy1;
  always_comb begin
    w_tx = ifa.tx; w_busy = ifa.busy; w_fd = ifa.frame_done;
    w_gid = ifa.grant_id; w_rdy0 = ifa.req0_ready; w_rdy1 = ifa.req1_ready;
    case (sel)
      1: begin
        w_tx = ifb.tx; w_busy = ifb.busy; w_fd = ifb.frame_done;
        w_gid = ifb.grant_id; w_rdy0 = ifb.req0_ready; w_rdy1 = ifb.req1_ready;
      end
      2: begin
        w_tx = ifc.tx; w_busy = ifc.busy; w_fd = ifc.frame_done;
        w_gid = ifc.grant_id; w_rdy0 = ifc.req0_ready; w_rdy1 = ifc.req1_ready;
      end
      3: begin
        w_tx = ifd.tx; w_busy = ifd.busy; w_fd = ifd.frame_done;
        w_gid = ifd.grant_id; w_rdy0 = ifd.req0_ready; w_rdy1 = ifd.req1_ready;
      end
      default: ;
    endcase
  end

  task automatic check_val(input string tag, input logic [31:0] act,
                           input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Called at a falling edge. Waits (bounded) for the expected requester to
  // see ready, lets the next rising edge accept, then checks every clock of
  // the frame against the bit pattern and the completion cycle after it.
  task automatic do_frame(input string tag, input int unsigned bc,
                          input logic [7:0] d, input bit pe, input logic pbit,
                          input int unsigned nstop, input logic gid,
                          input bit drop, output int unsigned waited);
    int unsigned total, tx_err, busy_err, fd_err, rdy_err, b;
    logic e;
    waited = 0;
    #1;
    while (!(gid ? w_rdy1 : w_rdy0) && waited < 20) begin
      @(negedge clk); #1;
      waited++;
    end
    check_val({tag, "_ready"}, gid ? w_rdy1 : w_rdy0, 1);
    check_val({tag, "_other_ready"}, gid ? w_rdy0 : w_rdy1, 0);
    if (gid ? w_rdy1 : w_rdy0) begin
      total = bc * (9 + (pe ? 1 : 0) + nstop);
      tx_err = 0; busy_err = 0; fd_err = 0; rdy_err = 0;
      @(posedge clk);
      for (int unsigned c = 0; c < total; c++) begin
        @(negedge clk);
        b = c / bc;
        if (b == 0)            e = 1'b0;
        else if (b <= 8)       e = d[b-1];
        else if (pe && b == 9) e = pbit;
        else                   e = 1'b1;
        if (w_tx !== e)          tx_err++;
        if (w_busy !== 1'b1)     busy_err++;
        if (w_fd !== 1'b0)       fd_err++;
        if ((w_rdy0 | w_rdy1) !== 1'b0) rdy_err++;
        if (c == 0 && drop) begin
          if (gid) r1v[sel] = 1'b0;
          else     r0v[sel] = 1'b0;
        end
      end
      check_val({tag, "_tx_bit_errs"}, tx_err, 0);
      check_val({tag, "_busy_errs"}, busy_err, 0);
      check_val({tag, "_early_done"}, fd_err, 0);
      check_val({tag, "_ready_while_busy"}, rdy_err, 0);
      @(negedge clk);
      check_val({tag, "_frame_done"}, w_fd, 1);
      check_val({tag, "_busy_end"}, w_busy, 0);
      check_val({tag, "_tx_idle"}, w_tx, 1);
      check_val({tag, "_grant_id"}, w_gid, gid);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin : main
    int unsigned w;
    logic fd_seen;
    for (int i = 0; i < 4; i++) begin
      r0v[i] = 1'b0; r1v[i] = 1'b0; r0d[i] = '0; r1d[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int unsigned s = 0; s < 4; s++) begin
      sel = s; #1;
      check_val("rst_tx", w_tx, 1);
      check_val("rst_busy", w_busy, 0);
      check_val("rst_done", w_fd, 0);
      check_val("rst_gid", w_gid, 0);
    end
    rst = 1'b0;
    @(negedge clk);

    // 0x55, 8N1, default bit period
    sel = 0;
    r0d[0] = 8'h55; r0v[0] = 1'b1;
    do_frame("t1", 868, 8'h55, 0, 1'b0, 1, 1'b0, 1, w);

    // valid withdrawn before any accept edge
    r0v[0] = 1'b1; #1;
    check_val("wd_ready_up", w_rdy0, 1);
    r0v[0] = 1'b0; #1;
    check_val("wd_ready_down", w_rdy0, 0);
    repeat (3) @(negedge clk);
    check_val("wd_no_busy", w_busy, 0);

    // simultaneous requests after reset: req0 then req1, one idle clock
    do_reset();
    r0d[0] = 8'h3C; r1d[0] = 8'hC3; r0v[0] = 1'b1; r1v[0] = 1'b1;
    do_frame("t2a", 868, 8'h3C, 0, 1'b0, 1, 1'b0, 1, w);
    do_frame("t2b", 868, 8'hC3, 0, 1'b0, 1, 1'b1, 1, w);
    check_val("t2_gap", w, 0);

    // parity on 0x07: even -> 1, odd -> 0
    sel = 1; r0d[1] = 8'h07; r0v[1] = 1'b1;
    do_frame("t3e", 10, 8'h07, 1, 1'b1, 1, 1'b0, 1, w);
    sel = 2; r0d[2] = 8'h07; r0v[2] = 1'b1;
    do_frame("t3o", 10, 8'h07, 1, 1'b0, 1, 1'b0, 1, w);

    // two stop bits
    sel = 3; r0d[3] = 8'hFF; r0v[3] = 1'b1;
    do_frame("t4", 10, 8'hFF, 0, 1'b0, 2, 1'b0, 1, w);

    // both held valid: alternating grants back to back
    do_reset();
    sel = 1; r0d[1] = 8'h12; r1d[1] = 8'h34; r0v[1] = 1'b1; r1v[1] = 1'b1;
    do_frame("t5f0", 10, 8'h12, 1, 1'b0, 1, 1'b0, 0, w);
    do_frame("t5f1", 10, 8'h34, 1, 1'b1, 1, 1'b1, 0, w);
    check_val("t5_gap1", w, 0);
    do_frame("t5f2", 10, 8'h12, 1, 1'b0, 1, 1'b0, 0, w);
    check_val("t5_gap2", w, 0);
    do_frame("t5f3", 10, 8'h34, 1, 1'b1, 1, 1'b1, 0, w);
    check_val("t5_gap3", w, 0);
    r0v[1] = 1'b0; r1v[1] = 1'b0;

    // reset in the middle of data bit 3 of 0xA5 (bit 3 = 0)
    sel = 0; r1d[0] = 8'hA5; r1v[0] = 1'b1; #1;
    check_val("t6_ready", w_rdy1, 1);
    @(posedge clk);
    @(negedge clk);
    r1v[0] = 1'b0;
    repeat (868 * 4 + 433) @(negedge clk);
    check_val("t6_tx_bit3", w_tx, 0);
    check_val("t6_busy_pre", w_busy, 1);
    rst = 1'b1; #1;
    check_val("t6_tx_async", w_tx, 1);
    check_val("t6_busy_async", w_busy, 0);
    check_val("t6_gid_async", w_gid, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    fd_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (w_fd) fd_seen = 1'b1;
    end
    check_val("t6_no_done", fd_seen, 0);
    r0d[0] = 8'h81; r0v[0] = 1'b1;
    do_frame("t6_after", 868, 8'h81, 0, 1'b0, 1, 1'b0, 1, w);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule
